// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the RV32 memory stage.
// Width encoding, FSM states, store-lane and alignment helpers.
package mem_access_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2,
    MEM_RSVD = 2'd3
  } mem_width_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2
  } ma_state_e;

  function automatic logic is_misaligned(
    input logic [1:0] width,
    input logic [1:0] off
  );
    logic bad;
    bad = 1'b0;
    case (width)
      MEM_HALF: bad = off[0];
      MEM_WORD: bad = (off != 2'd0);
      MEM_RSVD: bad = 1'b1;
      default:  bad = 1'b0;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] store_strb(
    input logic [1:0] width,
    input logic [1:0] off
  );
    logic [3:0] s;
    case (width)
      MEM_BYTE: s = 4'b0001 << off;
      MEM_HALF: s = 4'b0011 << off;
      default:  s = 4'b1111;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] store_data(
    input logic [1:0]  width,
    input logic [31:0] d
  );
    logic [31:0] w;
    case (width)
      MEM_BYTE: w = {4{d[7:0]}};
      MEM_HALF: w = {2{d[15:0]}};
      default:  w = d;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/load_extender.sv
// Aligns a read word to the accessed lane and
// sign- or zero-extends it to 32 bits.
module load_extender
  import mem_access_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [1:0]  width,
  input  logic        is_unsigned,
  output logic [31:0] result
);

  logic [31:0] x;

  assign x = rdata >> {offset, 3'b000};

  // Pick the lane and extend it
  always_comb begin
    result = rdata;
    case (width)
      MEM_BYTE: result = {{24{~is_unsigned & x[7]}}, x[7:0]};
      MEM_HALF: result = {{16{~is_unsigned & x[15]}}, x[15:0]};
      default:  result = rdata;
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// RV32 memory stage: runs loads/stores on a req/gnt/rvalid
// port and registers the MW bundle for writeback.
module memory_access
  import mem_access_pkg::*;
(
  input  logic        clk,
  input  logic        rstd,
  input  logic        EM_valid,
  input  logic [31:0] EM_pc,
  input  logic [31:0] EM_alu_result,
  input  logic [31:0] EM_w_data,
  input  logic [1:0]  EM_mem_access_width,
  input  logic [4:0]  EM_rd_addr,
  input  logic        EM_w_enable,
  input  logic        EM_is_load,
  input  logic        EM_is_store,
  input  logic        EM_is_load_unsigned,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        MW_valid,
  output logic [31:0] MW_pc,
  output logic [4:0]  MW_rd_addr,
  output logic        MW_w_enable,
  output logic [31:0] MW_w_data,
  output logic        MW_misaligned
);

  ma_state_e   state;
  logic [1:0]  lat_off;
  logic [1:0]  lat_width;
  logic        lat_uns;
  logic [4:0]  lat_rd;
  logic [31:0] lat_pc;
  logic        lat_we;
  logic        lat_store;

  logic        mem_op;
  logic        mis;
  logic        completing;
  logic [31:0] load_val;

  load_extender u_ext (
    .rdata       (dmem_rdata),
    .offset      (lat_off),
    .width       (lat_width),
    .is_unsigned (lat_uns),
    .result      (load_val)
  );

  // Decode the incoming op and the completion condition
  always_comb begin
    mem_op = EM_valid & (EM_is_load | EM_is_store);
    mis = is_misaligned(EM_mem_access_width,
                        EM_alu_result[1:0]);
    completing = (state == REQ & dmem_gnt & lat_store)
               | (state == WAIT_R & dmem_rvalid);
    stall = (state != IDLE & ~completing)
          | (state == IDLE & mem_op & ~mis);
  end

  // Transaction FSM with registered bus and MW outputs
  always_ff @(posedge clk) begin
    if (rstd) begin
      state         <= IDLE;
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_addr     <= '0;
      dmem_wstrb    <= '0;
      dmem_wdata    <= '0;
      MW_valid      <= 1'b0;
      MW_pc         <= '0;
      MW_rd_addr    <= '0;
      MW_w_enable   <= 1'b0;
      MW_w_data     <= '0;
      MW_misaligned <= 1'b0;
      lat_off       <= '0;
      lat_width     <= '0;
      lat_uns       <= 1'b0;
      lat_rd        <= '0;
      lat_pc        <= '0;
      lat_we        <= 1'b0;
      lat_store     <= 1'b0;
    end else begin
      MW_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_op & ~mis) begin
            lat_off    <= EM_alu_result[1:0];
            lat_width  <= EM_mem_access_width;
            lat_uns    <= EM_is_load_unsigned;
            lat_rd     <= EM_rd_addr;
            lat_pc     <= EM_pc;
            lat_we     <= EM_w_enable;
            lat_store  <= EM_is_store;
            dmem_req   <= 1'b1;
            dmem_we    <= EM_is_store;
            dmem_addr  <= {EM_alu_result[31:2], 2'b00};
            dmem_wstrb <= EM_is_store
                        ? store_strb(EM_mem_access_width,
                                     EM_alu_result[1:0])
                        : 4'b0000;
            dmem_wdata <= store_data(EM_mem_access_width,
                                     EM_w_data);
            state      <= REQ;
          end else if (EM_valid) begin
            MW_valid      <= 1'b1;
            MW_pc         <= EM_pc;
            MW_rd_addr    <= EM_rd_addr;
            MW_w_data     <= EM_alu_result;
            MW_w_enable   <= EM_w_enable & ~mem_op;
            MW_misaligned <= mem_op;
          end
        end
        REQ: begin
          if (dmem_gnt) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_wstrb <= 4'b0000;
            if (lat_store) begin
              MW_valid      <= 1'b1;
              MW_pc         <= lat_pc;
              MW_rd_addr    <= lat_rd;
              MW_w_data     <= {dmem_addr[31:2], lat_off};
              MW_w_enable   <= 1'b0;
              MW_misaligned <= 1'b0;
              state         <= IDLE;
            end else begin
              state <= WAIT_R;
            end
          end
        end
        WAIT_R: begin
          if (dmem_rvalid) begin
            MW_valid      <= 1'b1;
            MW_pc         <= lat_pc;
            MW_rd_addr    <= lat_rd;
            MW_w_data     <= load_val;
            MW_w_enable   <= lat_we;
            MW_misaligned <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// Self-checking bench for memory_access.
// Scoreboard of expected retirements checked by a monitor.
module tb_memory_access;

  logic        clk;
  logic        rstd;
  logic        EM_valid;
  logic [31:0] EM_pc;
  logic [31:0] EM_alu_result;
  logic [31:0] EM_w_data;
  logic [1:0]  EM_mem_access_width;
  logic [4:0]  EM_rd_addr;
  logic        EM_w_enable;
  logic        EM_is_load;
  logic        EM_is_store;
  logic        EM_is_load_unsigned;
  logic        stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        MW_valid;
  logic [31:0] MW_pc;
  logic [4:0]  MW_rd_addr;
  logic        MW_w_enable;
  logic [31:0] MW_w_data;
  logic        MW_misaligned;

  memory_access dut (
    .clk                 (clk),
    .rstd                (rstd),
    .EM_valid            (EM_valid),
    .EM_pc               (EM_pc),
    .EM_alu_result       (EM_alu_result),
    .EM_w_data           (EM_w_data),
    .EM_mem_access_width (EM_mem_access_width),
    .EM_rd_addr          (EM_rd_addr),
    .EM_w_enable         (EM_w_enable),
    .EM_is_load          (EM_is_load),
    .EM_is_store         (EM_is_store),
    .EM_is_load_unsigned (EM_is_load_unsigned),
    .stall               (stall),
    .dmem_req            (dmem_req),
    .dmem_we             (dmem_we),
    .dmem_addr           (dmem_addr),
    .dmem_wstrb          (dmem_wstrb),
    .dmem_wdata          (dmem_wdata),
    .dmem_gnt            (dmem_gnt),
    .dmem_rvalid         (dmem_rvalid),
    .dmem_rdata          (dmem_rdata),
    .MW_valid            (MW_valid),
    .MW_pc               (MW_pc),
    .MW_rd_addr          (MW_rd_addr),
    .MW_w_enable         (MW_w_enable),
    .MW_w_data           (MW_w_data),
    .MW_misaligned       (MW_misaligned)
  );

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] data;
    logic        chk_data;
    logic        mis;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ld_model(
    input logic [31:0] w,
    input logic [1:0]  o,
    input logic [1:0]  width,
    input logic        u
  );
    logic [7:0]  b;
    logic [15:0] h;
    case (o)
      2'd0: b = w[7:0];
      2'd1: b = w[15:8];
      2'd2: b = w[23:16];
      default: b = w[31:24];
    endcase
    h = o[1] ? w[31:16] : w[15:0];
    if (width == 2'd0)
      return u ? {24'h0, b} : {{24{b[7]}}, b};
    if (width == 2'd1)
      return u ? {16'h0, h} : {{16{h[15]}}, h};
    return w;
  endfunction

  function automatic logic mis_model(
    input logic [1:0]  width,
    input logic [31:0] a
  );
    return (width == 2'd1 && a[0])
        || (width == 2'd2 && a[1:0] != 2'd0)
        || (width == 2'd3);
  endfunction

  // Retirement monitor: every MW_valid pulse pops one entry
  always @(negedge clk) begin
    exp_t e;
    if (MW_valid === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL retire_unexpected pc=%h", MW_pc);
      end else begin
        e = sb.pop_front();
        if (MW_pc !== e.pc || MW_rd_addr !== e.rd
            || MW_w_enable !== e.we
            || MW_misaligned !== e.mis
            || (e.chk_data && MW_w_data !== e.data)) begin
          bad++;
          $display("FAIL retire pc=%h got rd=%0d we=%b data=%h mis=%b want pc=%h rd=%0d we=%b data=%h mis=%b",
                   MW_pc, MW_rd_addr, MW_w_enable, MW_w_data,
                   MW_misaligned, e.pc, e.rd, e.we, e.data,
                   e.mis);
        end
      end
    end
  end

  task automatic idle_inputs();
    EM_valid = 1'b0;
    EM_is_load = 1'b0;
    EM_is_store = 1'b0;
    EM_w_enable = 1'b0;
    EM_is_load_unsigned = 1'b0;
  endtask

  // Present one op, play the bus side, check handshake and latency
  task automatic do_op(
    input logic [31:0] pc,
    input logic [31:0] addr,
    input logic [31:0] d,
    input logic [1:0]  w,
    input logic [4:0]  rd,
    input logic        we,
    input logic        ld,
    input logic        st,
    input logic        uns,
    input int          gw,
    input int          rw,
    input logic [31:0] rdata
  );
    exp_t e;
    int t0;
    int lat;
    logic mem;
    logic mis;
    logic [3:0]  es;
    logic [31:0] ed;
    mem = ld | st;
    mis = mem && mis_model(w, addr);
    e.pc = pc;
    e.rd = rd;
    e.mis = mis;
    e.chk_data = !(mem && (mis || st));
    e.we = mem ? (ld && !mis && we) : we;
    e.data = (mem && !mis) ? ld_model(rdata, addr[1:0], w, uns)
                           : addr;
    sb.push_back(e);
    EM_valid = 1'b1;
    EM_pc = pc;
    EM_alu_result = addr;
    EM_w_data = d;
    EM_mem_access_width = w;
    EM_rd_addr = rd;
    EM_w_enable = we;
    EM_is_load = ld;
    EM_is_store = st;
    EM_is_load_unsigned = uns;
    t0 = cyc;
    #1;
    total++;
    if (stall !== (mem && !mis)) begin
      bad++;
      $display("FAIL stall_accept pc=%h got %b want %b",
               pc, stall, mem && !mis);
    end
    if (mem && !mis) begin
      if (!st) es = 4'h0;
      else if (w == 2'd0) es = 4'b0001 << addr[1:0];
      else if (w == 2'd1) es = 4'b0011 << addr[1:0];
      else es = 4'hf;
      if (w == 2'd0) ed = {4{d[7:0]}};
      else if (w == 2'd1) ed = {2{d[15:0]}};
      else ed = d;
      @(negedge clk);
      for (int i = 0; i <= gw; i++) begin
        total++;
        if (dmem_req !== 1'b1 || dmem_we !== st
            || dmem_addr !== {addr[31:2], 2'b00}
            || dmem_wstrb !== es
            || (st && dmem_wdata !== ed)) begin
          bad++;
          $display("FAIL bus_req pc=%h cyc%0d got req=%b we=%b a=%h s=%b d=%h want we=%b a=%h s=%b d=%h",
                   pc, i, dmem_req, dmem_we, dmem_addr,
                   dmem_wstrb, dmem_wdata, st,
                   {addr[31:2], 2'b00}, es, ed);
        end
        dmem_gnt = (i == gw);
        dmem_rvalid = ld && (i != gw);
        dmem_rdata = ~rdata;
        #1;
        total++;
        if (stall !== !(st && i == gw)) begin
          bad++;
          $display("FAIL stall_req pc=%h got %b want %b",
                   pc, stall, !(st && i == gw));
        end
        @(negedge clk);
      end
      dmem_gnt = 1'b0;
      dmem_rvalid = 1'b0;
      if (ld) begin
        for (int i = 0; i <= rw; i++) begin
          total++;
          if (dmem_req !== 1'b0) begin
            bad++;
            $display("FAIL req_drop pc=%h got %b want 0",
                     pc, dmem_req);
          end
          dmem_rvalid = (i == rw);
          dmem_rdata = rdata;
          #1;
          total++;
          if (stall !== (i != rw)) begin
            bad++;
            $display("FAIL stall_wait pc=%h got %b want %b",
                     pc, stall, i != rw);
          end
          @(negedge clk);
        end
        dmem_rvalid = 1'b0;
      end
    end else begin
      @(negedge clk);
      total++;
      if (dmem_req !== 1'b0) begin
        bad++;
        $display("FAIL no_req pc=%h got %b want 0",
                 pc, dmem_req);
      end
    end
    idle_inputs();
    if (!mem || mis) lat = 1;
    else if (st) lat = gw + 2;
    else lat = gw + rw + 3;
    total++;
    if (MW_valid !== 1'b1 || cyc - t0 != lat) begin
      bad++;
      $display("FAIL latency pc=%h got valid=%b cycles=%0d want 1 %0d",
               pc, MW_valid, cyc - t0, lat);
    end
  endtask

  task automatic test_reset();
    rstd = 1'b1;
    idle_inputs();
    dmem_gnt = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata = '0;
    EM_pc = '0;
    EM_alu_result = '0;
    EM_w_data = '0;
    EM_mem_access_width = '0;
    EM_rd_addr = '0;
    repeat (3) @(negedge clk);
    total++;
    if (dmem_req !== 1'b0 || dmem_we !== 1'b0
        || dmem_wstrb !== 4'h0 || dmem_addr !== 32'h0
        || dmem_wdata !== 32'h0 || stall !== 1'b0) begin
      bad++;
      $display("FAIL reset_bus got req=%b we=%b s=%h a=%h d=%h st=%b want zeros",
               dmem_req, dmem_we, dmem_wstrb, dmem_addr,
               dmem_wdata, stall);
    end
    total++;
    if (MW_valid !== 1'b0 || MW_w_enable !== 1'b0
        || MW_misaligned !== 1'b0 || MW_pc !== 32'h0
        || MW_rd_addr !== 5'h0 || MW_w_data !== 32'h0) begin
      bad++;
      $display("FAIL reset_mw got v=%b we=%b m=%b pc=%h rd=%0d d=%h want zeros",
               MW_valid, MW_w_enable, MW_misaligned, MW_pc,
               MW_rd_addr, MW_w_data);
    end
    rstd = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_alu();
    do_op(32'h100, 32'h1234, 32'h0, 2'd2, 5'd5, 1'b1,
          1'b0, 1'b0, 1'b0, 0, 0, 32'h0);
    do_op(32'h104, 32'hdead0001, 32'h0, 2'd3, 5'd0, 1'b0,
          1'b0, 1'b0, 1'b0, 0, 0, 32'h0);
  endtask

  task automatic test_store();
    do_op(32'h200, 32'h1003, 32'hab, 2'd0, 5'd1, 1'b0,
          1'b0, 1'b1, 1'b0, 2, 0, 32'h0);
    do_op(32'h204, 32'h1002, 32'h1234cdef, 2'd1, 5'd2,
          1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 32'h0);
    do_op(32'h208, 32'h1008, 32'hcafef00d, 2'd2, 5'd3,
          1'b0, 1'b0, 1'b1, 1'b0, 1, 0, 32'h0);
  endtask

  task automatic test_load();
    do_op(32'h300, 32'h2002, 32'h0, 2'd1, 5'd6, 1'b1,
          1'b1, 1'b0, 1'b0, 0, 0, 32'h80010000);
    do_op(32'h304, 32'h2002, 32'h0, 2'd1, 5'd7, 1'b1,
          1'b1, 1'b0, 1'b1, 0, 0, 32'h80010000);
    do_op(32'h308, 32'h2001, 32'h0, 2'd0, 5'd8, 1'b1,
          1'b1, 1'b0, 1'b0, 1, 1, 32'h12349678);
    do_op(32'h30c, 32'h2003, 32'h0, 2'd0, 5'd9, 1'b1,
          1'b1, 1'b0, 1'b1, 0, 2, 32'hf2345678);
    do_op(32'h310, 32'h2004, 32'h0, 2'd2, 5'd10, 1'b1,
          1'b1, 1'b0, 1'b0, 2, 3, 32'h89abcdef);
    do_op(32'h314, 32'h2000, 32'h0, 2'd1, 5'd11, 1'b0,
          1'b1, 1'b0, 1'b0, 0, 1, 32'h0000ff80);
  endtask

  task automatic test_misaligned();
    do_op(32'h400, 32'h2001, 32'h0, 2'd2, 5'd12, 1'b1,
          1'b1, 1'b0, 1'b0, 0, 0, 32'h0);
    do_op(32'h404, 32'h1001, 32'h55, 2'd1, 5'd13, 1'b0,
          1'b0, 1'b1, 1'b0, 0, 0, 32'h0);
    do_op(32'h408, 32'h2000, 32'h0, 2'd3, 5'd14, 1'b1,
          1'b1, 1'b0, 1'b0, 0, 0, 32'h0);
  endtask

  task automatic test_reset_mid();
    EM_valid = 1'b1;
    EM_pc = 32'h500;
    EM_alu_result = 32'h3000;
    EM_mem_access_width = 2'd2;
    EM_rd_addr = 5'd15;
    EM_w_enable = 1'b1;
    EM_is_load = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    total++;
    if (stall !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid_wait got stall=%b want 1", stall);
    end
    rstd = 1'b1;
    idle_inputs();
    @(negedge clk);
    rstd = 1'b0;
    total++;
    if (dmem_req !== 1'b0 || stall !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_idle got req=%b stall=%b want 0 0",
               dmem_req, stall);
    end
    dmem_rvalid = 1'b1;
    dmem_rdata = 32'h11223344;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    total++;
    if (MW_valid !== 1'b0 || stall !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_late got valid=%b stall=%b want 0 0",
               MW_valid, stall);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    logic [1:0]  w;
    int k;
    for (int n = 0; n < 24; n++) begin
      k = $urandom_range(0, 2);
      w = 2'($urandom_range(0, 2));
      a = 32'h4000 + 32'($urandom_range(0, 255)) * 4;
      if (w == 2'd0) a = a + 32'($urandom_range(0, 3));
      if (w == 2'd1) a = a + 32'($urandom_range(0, 1)) * 2;
      do_op(32'h600 + 32'(n) * 4, a, $urandom, w,
            5'($urandom_range(1, 31)), 1'b1,
            k == 0, k == 1, 1'($urandom_range(0, 1)),
            $urandom_range(0, 2), $urandom_range(0, 2),
            $urandom);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_store();
    test_load();
    test_misaligned();
    test_reset_mid();
    test_back_to_back();
    repeat (3) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain got %0d pending want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memory_access.md
# memory_access

Pipeline memory stage directly downstream of the execute stage. It consumes the execute/memory (EM_*) pipeline register: ALU result/address, store data, access width, destination and load/store flags. It runs load/store transactions on a request/grant/response data-memory port with arbitrary wait states and stalls upstream while a transaction is in flight. It registers the memory/writeback (MW_*) result, including aligned and extended load data, for the writeback stage.

## Interface
Parameters: none. All widths are fixed for RV32.

Ports:
- clk  in  1  clock; all state updates on posedge
- rstd  in  1  reset, synchronous, active-high
- EM_valid  in  1  an instruction is present on the EM_* inputs
- EM_pc  in  32  instruction pc (debug, passed through)
- EM_alu_result  in  32  byte address for load/store; result otherwise
- EM_w_data  in  32  store source data
- EM_mem_access_width  in  2  0 byte, 1 half, 2 word, 3 reserved
- EM_rd_addr  in  5  destination register
- EM_w_enable  in  1  register write requested
- EM_is_load  in  1  load instruction
- EM_is_store  in  1  store instruction
- EM_is_load_unsigned  in  1  zero-extend, not sign-extend
- stall  out  1  upstream must hold EM_* stable this cycle
- dmem_req  out  1  request valid
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word address ({addr[31:2],2'b00})
- dmem_wstrb  out  4  byte-lane write enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_gnt  in  1  request accepted this cycle
- dmem_rvalid  in  1  read data valid
- dmem_rdata  in  32  read word
- MW_valid  out  1  MW_* holds a retiring instruction
- MW_pc  out  32  pc of retiring instruction
- MW_rd_addr  out  5  destination register
- MW_w_enable  out  1  write rd (0 for store, misaligned or bubble)
- MW_w_data  out  32  writeback data
- MW_misaligned  out  1  misaligned/illegal access flag

## Operation
- FSM states: IDLE, REQ, WAIT_R.
- A mem op is EM_valid & (EM_is_load | EM_is_store).
- An access is misaligned when any of these hold:
  - half access with addr[0]=1;
  - word access with addr[1:0]≠0;
  - width is 3 (reserved).

IDLE:
- Non-mem op: retire next edge. MW_w_data=EM_alu_result; MW_w_enable=EM_w_enable.
- Misaligned mem op: no bus access. Retire next edge with MW_misaligned=1 and MW_w_enable=0.
- Aligned mem op:
  - latch the address, wstrb, wdata, width, unsigned flag, rd, pc and load/store flags;
  - go to REQ.

REQ:
- Drive dmem_req=1 with the latched fields.
- On dmem_gnt, a store retires (MW_w_enable=0) and the FSM goes to IDLE.
- On dmem_gnt, a load goes to WAIT_R.
- dmem_rvalid is ignored in REQ.

WAIT_R:
- On dmem_rvalid, retire with MW_w_data = the extracted load value and MW_w_enable = the latched w_enable. Go to IDLE.

Store lanes (o = addr[1:0]):
- byte: wdata={4{d[7:0]}}, wstrb=4'b0001<<o
- half: wdata={2{d[15:0]}}, wstrb=4'b0011<<o
- word: wdata=d, wstrb=4'b1111
- For loads, dmem_we=0 and wstrb=0.

Load extract:
- Shift: x = rdata >> (8·o).
- byte: use x[7:0]; half: use x[15:0].
- Extend with sign or zero per the unsigned flag. Word uses rdata unchanged.

Stall:
- stall = (state≠IDLE & ¬completing) | (state=IDLE & aligned mem op).
- "completing" means gnt for a store in REQ, or rvalid in WAIT_R.
- Stall drops in the completion cycle, so upstream advances at the same edge the result retires.

MW register rules:
- MW_valid is 1 for exactly one cycle per retired instruction and 0 otherwise. This includes bubbles and in-flight cycles.
- The other MW_* fields hold their last value when MW_valid=0.

## Timing
Reset values:
- state=IDLE;
- dmem_req=0, dmem_we=0, dmem_wstrb=0;
- MW_valid=0, MW_w_enable=0, MW_misaligned=0;
- MW_pc, MW_rd_addr, MW_w_data, dmem_addr, dmem_wdata = 0.

Reset mid-transaction:
- Abort and return to IDLE; dmem_req drops at that edge.
- A gnt or rvalid arriving after reset is ignored.

Latency:
- Non-mem or misaligned op: 1 cycle (MW_valid the cycle after the op is presented).
- Store: 1 + cycles until gnt (minimum 2).
- Load: 1 + gnt wait + rvalid wait (minimum 3: accept, REQ with gnt, WAIT_R with rvalid).

Handshake rules:
- dmem_req and all dmem_* fields stay stable from REQ entry until gnt.
- Unbounded wait states are legal.

## Structure
- Package mem_access_pkg:
  - width enum MEM_BYTE=0, MEM_HALF=1, MEM_WORD=2, MEM_RSVD=3;
  - FSM state enum;
  - store-lane and misalignment helper functions shared with the bus model.
- Sub-module load_extender: combinational. Inputs are rdata, offset, width and unsigned; output is the 32-bit writeback value.

## Test plan
- ALU op: EM_valid=1, alu_result=0x1234, w_enable=1, rd=5 → next cycle MW_valid=1, MW_w_data=0x1234, rd=5, stall never asserted.
- Byte store: addr 0x1003, data 0xAB, gnt after 2 wait cycles → dmem_addr=0x1000, wstrb=0b1000, wdata=0xABABABAB held stable through the wait; store retires with MW_w_enable=0; stall low in the gnt cycle.
- Signed half load: addr 0x2002, rdata=0x8001_0000 → MW_w_data=0xFFFF8001. With the unsigned flag → 0x00008001. Total latency 3 cycles at zero wait.
- Misaligned: word load at 0x2001 → no dmem_req; next cycle MW_valid=1, MW_misaligned=1, MW_w_enable=0.
- Reset in WAIT_R, then a late rvalid → state IDLE, MW_valid stays 0, nothing retired.
- Back-to-back load, store, ALU ops → each retires exactly once, in order, with no duplicate MW_valid pulses.
